// File: rtl/stopwatch_pkg.sv
// Shared constants, state types and helpers for the stopwatch command controller.
package stopwatch_pkg;

  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_S_UP = 8'h53;
  localparam logic [7:0] ASCII_S_LO = 8'h73;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_Q_UP = 8'h51;
  localparam logic [7:0] ASCII_Q_LO = 8'h71;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Four digits plus CR LF.
  localparam int REPORT_LEN = 6;

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} run_state_t;

  typedef enum logic [1:0] {T_IDLE, T_CONV, T_SEND, T_WAIT} tx_state_t;

  // One decoded control event, registered for one cycle before it acts.
  typedef struct packed {
    logic toggle;
    logic set_run;
    logic set_stop;
    logic clear;
  } run_ev_t;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic b);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[14:0], b};
  endfunction

  // Byte k of a count report: ASCII digits MSD first, then CR, LF.
  function automatic logic [7:0] report_byte(input logic [2:0] k, input logic [15:0] bcd);
    case (k)
      3'd0:    return {4'h3, bcd[15:12]};
      3'd1:    return {4'h3, bcd[11:8]};
      3'd2:    return {4'h3, bcd[7:4]};
      3'd3:    return {4'h3, bcd[3:0]};
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, 16-bit BCD out.
// done is high for the cycle after the last shift; bcd holds until the next start.
module bin2bcd_seq
  import stopwatch_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0] sh_q;
  logic [15:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  // Load on start, then shift one bit per cycle until the bit counter empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= CW'(CNT_W);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        bcd_q <= dd_step(bcd_q, sh_q[CNT_W-1]);
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done = run_q && (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch control: merges button edges and UART command bytes into run/clear
// controls and sends ASCII count reports over the UART transmitter.
// Optional: define CMD_ECHO_EN to echo each accepted R/S/C command byte.
module stopwatch_cmd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W   = 14,
  parameter int MAX_DEC = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_btn_run,
  input  logic             i_btn_clear,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_tx_done,
  output logic             o_run_on,
  output logic             o_clr_on,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] MAX_CLAMP       = CNT_W'(MAX_DEC);
  localparam logic [2:0]       LAST_REPORT_IDX = 3'(REPORT_LEN - 1);

  logic             btn_run_q, btn_clr_q;
  logic             run_edge, clr_edge;
  logic             is_r, is_s, is_c, is_q, uart_cmd, q_acc;
  run_ev_t          ev_d, ev_q;
  logic             rep_req_q;
  logic [CNT_W-1:0] cap_q;
  run_state_t       run_state_q, run_state_d;
  logic             clr_d, clr_q;
  tx_state_t        tx_state_q, tx_state_d;
  logic [2:0]       idx_q, idx_d, last_q, last_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             conv_start, conv_done;
  logic [15:0]      bcd;
  logic             echo_go;
  logic [7:0]       echo_byte;

  assign run_edge = i_btn_run && !btn_run_q;
  assign clr_edge = i_btn_clear && !btn_clr_q;

  // Decode the received byte and arbitrate it against the button edges.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    ev_d     = '0;
    is_r     = i_rx_done && (i_rx_data == ASCII_R_UP || i_rx_data == ASCII_R_LO);
    is_s     = i_rx_done && (i_rx_data == ASCII_S_UP || i_rx_data == ASCII_S_LO);
    is_c     = i_rx_done && (i_rx_data == ASCII_C_UP || i_rx_data == ASCII_C_LO);
    is_q     = i_rx_done && (i_rx_data == ASCII_Q_UP || i_rx_data == ASCII_Q_LO);
    uart_cmd = is_r || is_s || is_c || is_q;
    if (uart_cmd) begin
      ev_d.set_run  = is_r;
      ev_d.set_stop = is_s;
      ev_d.clear    = is_c;
    end else begin
      ev_d.toggle = run_edge;
      ev_d.clear  = clr_edge && !run_edge;
    end
  end

  // A report request is only taken when the transmitter is idle and none is pending.
  assign q_acc = is_q && (tx_state_q == T_IDLE) && !rep_req_q;

  // Edge history, event pipeline stage and clamped count capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_run_q <= 1'b0;
      btn_clr_q <= 1'b0;
      ev_q      <= '0;
      rep_req_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      btn_run_q <= i_btn_run;
      btn_clr_q <= i_btn_clear;
      ev_q      <= ev_d;
      rep_req_q <= q_acc;
      if (q_acc) cap_q <= (i_count > MAX_CLAMP) ? MAX_CLAMP : i_count;
    end
  end

`ifdef CMD_ECHO_EN
  logic       echo_req_q;
  logic [7:0] echo_byte_q;

  // Remember the accepted command byte for a one-byte acknowledgement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_req_q  <= 1'b0;
      echo_byte_q <= 8'h00;
    end else begin
      echo_req_q <= is_r || is_s || is_c;
      if (is_r || is_s || is_c) echo_byte_q <= i_rx_data;
    end
  end

  // A clear that lands while running has no effect, so it is not acknowledged.
  assign echo_go   = echo_req_q && (!ev_q.clear || run_state_q == STOP);
  assign echo_byte = echo_byte_q;
`else
  assign echo_go   = 1'b0;
  assign echo_byte = 8'h00;
`endif

  // Run FSM state register and clear pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_state_q <= STOP;
      clr_q       <= 1'b0;
    end else begin
      run_state_q <= run_state_d;
      clr_q       <= clr_d;
    end
  end

  // Run FSM next state: forced commands first, then toggle, then clear in STOP.
  always_comb begin
    run_state_d = run_state_q;
    clr_d       = 1'b0;
    if (ev_q.set_run) begin
      run_state_d = RUN;
    end else if (ev_q.set_stop) begin
      run_state_d = STOP;
    end else if (ev_q.toggle) begin
      run_state_d = (run_state_q == RUN) ? STOP : RUN;
    end else if (ev_q.clear && run_state_q == STOP) begin
      clr_d = 1'b1;
    end
  end

  // Run FSM outputs.
  always_comb begin
    o_run_on = (run_state_q == RUN);
    o_clr_on = clr_q;
  end

  bin2bcd_seq #(.CNT_W(CNT_W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (cap_q),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // TX FSM state register with byte index, length and held output byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= T_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // TX FSM next state: convert, then send/wait per byte until the last one is done.
  always_comb begin
    tx_state_d = tx_state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    conv_start = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (rep_req_q) begin
          tx_state_d = T_CONV;
          conv_start = 1'b1;
          idx_d      = 3'd0;
          last_d     = LAST_REPORT_IDX;
        end else if (echo_go) begin
          tx_state_d = T_SEND;
          idx_d      = 3'd0;
          last_d     = 3'd0;
          tx_data_d  = echo_byte;
        end
      end
      T_CONV: begin
        if (conv_done) begin
          tx_state_d = T_SEND;
          tx_data_d  = report_byte(3'd0, bcd);
        end
      end
      T_SEND: tx_state_d = T_WAIT;
      T_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == last_q) begin
            tx_state_d = T_IDLE;
          end else begin
            tx_state_d = T_SEND;
            idx_d      = idx_q + 3'd1;
            tx_data_d  = report_byte(idx_q + 3'd1, bcd);
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX FSM outputs.
  always_comb begin
    o_tx_start = (tx_state_q == T_SEND);
    o_busy     = (tx_state_q != T_IDLE);
    o_tx_data  = tx_data_q;
  end

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed bench for stopwatch_cmd_ctrl (default build, CMD_ECHO_EN undefined).
module tb_stopwatch_cmd_ctrl;

  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_btn_run, i_btn_clear;
  logic [7:0]       i_rx_data;
  logic             i_rx_done;
  logic [CNT_W-1:0] i_count;
  logic             i_tx_done;
  logic             o_run_on, o_clr_on, o_tx_start, o_busy;
  logic [7:0]       o_tx_data;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int snap;

  stopwatch_cmd_ctrl #(.CNT_W(CNT_W), .MAX_DEC(9999)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_btn_run   (i_btn_run),
    .i_btn_clear (i_btn_clear),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_count     (i_count),
    .i_tx_done   (i_tx_done),
    .o_run_on    (o_run_on),
    .o_clr_on    (o_clr_on),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_tx_start) start_cnt <= start_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic wait_start(output int waits);
    waits = 0;
    while (!o_tx_start && waits < 40) begin
      tick();
      waits++;
    end
  endtask

  // Serve nbytes of a report, checking latency, data, pulse width and hold.
  task automatic do_report(input string tag, input logic [47:0] exp_bytes,
                           input int first_wait, input int nbytes);
    int waits;
    logic [7:0] eb;
    for (int k = 0; k < nbytes; k++) begin
      eb = exp_bytes[47-8*k -: 8];
      wait_start(waits);
      check({tag, "_lat"}, waits, (k == 0) ? first_wait : 0);
      check({tag, "_data"}, o_tx_data, eb);
      tick();
      check({tag, "_pulse"}, o_tx_start, 1'b0);
      check({tag, "_busy"}, o_busy, 1'b1);
      tick();
      check({tag, "_hold"}, o_tx_data, eb);
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
    end
    if (nbytes == 6) check({tag, "_idle"}, o_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_btn_run = 1'b0; i_btn_clear = 1'b0;
    i_rx_data = 8'h00; i_rx_done = 1'b0;
    i_count = '0; i_tx_done = 1'b0;
    repeat (3) tick();
    check("rst_run", o_run_on, 1'b0);
    check("rst_clr", o_clr_on, 1'b0);
    check("rst_start", o_tx_start, 1'b0);
    check("rst_data", o_tx_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    reset = 1'b0;
    repeat (2) tick();

    // 'R' takes effect one cycle after acceptance; 'S' stops.
    send_byte("R");
    check("r_latency", o_run_on, 1'b0);
    tick();
    check("r_run", o_run_on, 1'b1);
    send_byte("s");
    tick();
    check("s_stop", o_run_on, 1'b0);

    // 'C' in STOP: exactly one clear pulse.
    send_byte("c");
    check("c_latency", o_clr_on, 1'b0);
    tick();
    check("c_pulse", o_clr_on, 1'b1);
    tick();
    check("c_width", o_clr_on, 1'b0);

    // Clear button while running is ignored.
    send_byte("R");
    tick();
    i_btn_clear = 1'b1;
    tick();
    tick();
    check("clr_in_run", o_clr_on, 1'b0);
    tick();
    check("clr_in_run2", o_clr_on, 1'b0);
    check("clr_in_run_r", o_run_on, 1'b1);
    i_btn_clear = 1'b0;
    tick();

    // 'R' beats a simultaneous run-button edge (toggle would have stopped).
    i_btn_run = 1'b1;
    send_byte("R");
    tick();
    tick();
    check("r_vs_btn", o_run_on, 1'b1);
    i_btn_run = 1'b0;
    tick();

    // 'S' with a run-button edge from RUN ends in STOP.
    i_btn_run = 1'b1;
    send_byte("S");
    tick();
    tick();
    check("s_vs_btn", o_run_on, 1'b0);
    i_btn_run = 1'b0;
    tick();

    // Both buttons rise together in STOP: run wins, no clear.
    i_btn_run = 1'b1;
    i_btn_clear = 1'b1;
    tick();
    tick();
    check("both_run", o_run_on, 1'b1);
    check("both_clr", o_clr_on, 1'b0);
    i_btn_run = 1'b0;
    i_btn_clear = 1'b0;
    tick();
    send_byte("S");
    tick();

    // Report of 42.
    i_count = 14'd42;
    send_byte("Q");
    check("q_busy_lat", o_busy, 1'b0);
    tick();
    check("q_busy", o_busy, 1'b1);
    do_report("rep42", 48'h3030_3432_0D0A, CNT_W + 1, 6);

    // Clamped report; a second 'Q' mid-report is dropped.
    snap = start_cnt;
    i_count = 14'd16000;
    send_byte("q");
    tick();
    i_count = 14'd5;
    send_byte("Q");
    do_report("rep9999", 48'h3939_3939_0D0A, CNT_W, 6);
    repeat (30) tick();
    check("drop_q_count", start_cnt - snap, 6);
    check("drop_q_busy", o_busy, 1'b0);

    // Reset during the third byte clears everything asynchronously.
    send_byte("R");
    tick();
    i_count = 14'd7;
    send_byte("Q");
    do_report("rep7", 48'h3030_3037_0D0A, CNT_W + 2, 2);
    begin
      int waits;
      wait_start(waits);
      check("third_lat", waits, 0);
      check("third_data", o_tx_data, 8'h30);
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_run", o_run_on, 1'b0);
    check("mid_rst_clr", o_clr_on, 1'b0);
    check("mid_rst_start", o_tx_start, 1'b0);
    check("mid_rst_data", o_tx_data, 8'h00);
    check("mid_rst_busy", o_busy, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Full report after release.
    i_count = 14'd1234;
    send_byte("Q");
    do_report("rep1234", 48'h3132_3334_0D0A, CNT_W + 2, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
